// File: rtl/shared_reg_arbiter_pkg.sv
// shared_reg_arbiter_pkg: FSM state type and default sizing shared by the arbiter files
package shared_reg_arbiter_pkg;
   typedef enum logic {IDLE, GRANT} state_t;
   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker (rotate, priority-encode, un-rotate) starting after ptr
module rr_pick
   import shared_reg_arbiter_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [PW-1:0]   winner,
   output logic            any
);
   logic [PW-1:0]     start;
   logic [PW-1:0]     off;
   logic [2*NREQ-1:0] dbl;
   int                sum;
   always_comb begin
      start = (int'(ptr) == NREQ-1) ? '0 : ptr + 1'b1;
      dbl = {req, req} >> start;
      off = '0;
      for (int i = NREQ-1; i >= 0; i--)
         if (dbl[i]) off = PW'(i);
      sum = int'(start) + int'(off);
      winner = PW'((sum >= NREQ) ? sum - NREQ : sum);
   end
   assign any = |req;
endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin write arbiter and sole writer of one shared WIDTH-bit register
module shared_reg_arbiter
   import shared_reg_arbiter_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*WIDTH-1:0]    wdata,
   input  logic                     clr,
   output logic [NREQ-1:0]          gnt,
   output logic                     busy,
   output logic [WIDTH-1:0]         q,
   output logic [$clog2(NREQ)-1:0]  q_owner,
   output logic                     q_valid
);
   localparam int PW = $clog2(NREQ);
   state_t          state, state_nx;
   logic [PW-1:0]   ptr, win, pick;
   logic            any_req, start_grant;
   logic [NREQ-1:0] gnt_nx;
   rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req    (req),
      .ptr    (ptr),
      .winner (pick),
      .any    (any_req)
   );
   always_comb begin
      start_grant = (state == IDLE) && any_req;
      state_nx = start_grant ? GRANT : IDLE;
      gnt_nx = start_grant ? NREQ'(1) << pick : '0;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         gnt <= '0;
         win <= '0;
         ptr <= PW'(NREQ-1);
      end else begin
         state <= state_nx;
         gnt <= gnt_nx;
         if (start_grant) win <= pick;
         if (state == GRANT) ptr <= win;
      end
   end
   // clr beats a coinciding commit and leaves q_owner alone
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
         q_owner <= '0;
         q_valid <= 1'b0;
      end else if (clr) begin
         q <= '0;
         q_valid <= 1'b0;
      end else if (state == GRANT) begin
         q <= wdata[int'(win)*WIDTH +: WIDTH];
         q_owner <= win;
         q_valid <= 1'b1;
      end
   end
   assign busy = (state == GRANT);
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: table-driven scoreboard bench for shared_reg_arbiter plus async-reset sequence
module tb_shared_reg_arbiter;
   import shared_reg_arbiter_pkg::*;
   localparam int N = DEF_NREQ;
   localparam int W = DEF_WIDTH;
   typedef struct {
      logic [N-1:0]   req;
      logic           clr;
      logic [N*W-1:0] wd;
      logic [N-1:0]   gnt;
      logic           busy;
      logic [W-1:0]   q;
      logic [1:0]     own;
      logic           v;
   } vec_t;
   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 clr = 1'b0;
   logic [N-1:0]         req = '0;
   logic [N*W-1:0]       wdata = '0;
   logic [N-1:0]         gnt;
   logic                 busy, q_valid;
   logic [W-1:0]         q;
   logic [$clog2(N)-1:0] q_owner;
   int                   checks = 0;
   int                   errors = 0;
   vec_t                 vecs[$];
   vec_t                 sb[$];
   always #5 clk = ~clk;
   shared_reg_arbiter #(.NREQ(N), .WIDTH(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .wdata   (wdata),
      .clr     (clr),
      .gnt     (gnt),
      .busy    (busy),
      .q       (q),
      .q_owner (q_owner),
      .q_valid (q_valid)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic vec_t mk(input logic [N-1:0] r, input logic c, input logic [N*W-1:0] d,
                               input logic [N-1:0] g, input logic b, input logic [W-1:0] qq,
                               input logic [1:0] o, input logic v);
      vec_t t;
      t.req = r; t.clr = c; t.wd = d; t.gnt = g; t.busy = b; t.q = qq; t.own = o; t.v = v;
      return t;
   endfunction
   task automatic chk_all(input string tag, input logic [N-1:0] g, input logic b,
                          input logic [W-1:0] qq, input logic [1:0] o, input logic v);
      chk({tag, " gnt"}, 32'(gnt), 32'(g));
      chk({tag, " busy"}, 32'(busy), 32'(b));
      chk({tag, " q"}, 32'(q), 32'(qq));
      chk({tag, " q_owner"}, 32'(q_owner), 32'(o));
      chk({tag, " q_valid"}, 32'(q_valid), 32'(v));
   endtask
   initial begin
      logic [N*W-1:0] d, d3c, d5a;
      vec_t e;
      d   = 32'h443322A5;
      d3c = 32'h44333CA5;
      d5a = 32'h4433225A;
      // requester 0 alone from reset
      vecs.push_back(mk(4'b0001, 0, d,   4'b0001, 1, 8'h00, 0, 0));
      vecs.push_back(mk(4'b0001, 0, d,   4'b0000, 0, 8'hA5, 0, 1));
      vecs.push_back(mk(4'b0000, 0, d,   4'b0000, 0, 8'hA5, 0, 1));
      // all requesting: rotation 1,2,3,0,1
      vecs.push_back(mk(4'b1111, 0, d,   4'b0010, 1, 8'hA5, 0, 1));
      vecs.push_back(mk(4'b1111, 0, d,   4'b0000, 0, 8'h22, 1, 1));
      vecs.push_back(mk(4'b1111, 0, d,   4'b0100, 1, 8'h22, 1, 1));
      vecs.push_back(mk(4'b1111, 0, d,   4'b0000, 0, 8'h33, 2, 1));
      vecs.push_back(mk(4'b1111, 0, d,   4'b1000, 1, 8'h33, 2, 1));
      vecs.push_back(mk(4'b1111, 0, d,   4'b0000, 0, 8'h44, 3, 1));
      vecs.push_back(mk(4'b1111, 0, d,   4'b0001, 1, 8'h44, 3, 1));
      vecs.push_back(mk(4'b1111, 0, d,   4'b0000, 0, 8'hA5, 0, 1));
      vecs.push_back(mk(4'b1111, 0, d,   4'b0010, 1, 8'hA5, 0, 1));
      vecs.push_back(mk(4'b1111, 0, d,   4'b0000, 0, 8'h22, 1, 1));
      // 0101: 2 then wrap to 0 then 2
      vecs.push_back(mk(4'b0101, 0, d,   4'b0100, 1, 8'h22, 1, 1));
      vecs.push_back(mk(4'b0101, 0, d,   4'b0000, 0, 8'h33, 2, 1));
      vecs.push_back(mk(4'b0101, 0, d,   4'b0001, 1, 8'h33, 2, 1));
      vecs.push_back(mk(4'b0101, 0, d,   4'b0000, 0, 8'hA5, 0, 1));
      vecs.push_back(mk(4'b0101, 0, d,   4'b0100, 1, 8'hA5, 0, 1));
      vecs.push_back(mk(4'b0101, 0, d,   4'b0000, 0, 8'h33, 2, 1));
      // clr during requester 1's grant suppresses the 3C write
      vecs.push_back(mk(4'b0010, 0, d3c, 4'b0010, 1, 8'h33, 2, 1));
      vecs.push_back(mk(4'b0010, 1, d3c, 4'b0000, 0, 8'h00, 2, 0));
      vecs.push_back(mk(4'b1111, 0, d,   4'b0100, 1, 8'h00, 2, 0));
      vecs.push_back(mk(4'b1111, 0, d,   4'b0000, 0, 8'h33, 2, 1));
      vecs.push_back(mk(4'b0000, 1, d,   4'b0000, 0, 8'h00, 2, 0));
      // winner drops req during its grant cycle
      vecs.push_back(mk(4'b0001, 0, d,   4'b0001, 1, 8'h00, 2, 0));
      vecs.push_back(mk(4'b0000, 0, d5a, 4'b0000, 0, 8'h5A, 0, 1));
      vecs.push_back(mk(4'b0000, 0, d5a, 4'b0000, 0, 8'h5A, 0, 1));
      vecs.push_back(mk(4'b0000, 0, d5a, 4'b0000, 0, 8'h5A, 0, 1));
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      chk_all("reset", 4'b0000, 0, 8'h00, 0, 0);
      reset = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         req = vecs[i].req;
         clr = vecs[i].clr;
         wdata = vecs[i].wd;
         sb.push_back(vecs[i]);
         @(negedge clk);
         e = sb.pop_front();
         chk_all($sformatf("row%0d", i), e.gnt, e.busy, e.q, e.own, e.v);
      end
      // async reset in the middle of a grant
      req = 4'b1000;
      wdata = d;
      @(posedge clk);
      #2;
      chk("midgrant gnt", 32'(gnt), 32'h8);
      chk("midgrant busy", 32'(busy), 32'h1);
      reset = 1'b0;
      #1;
      chk_all("async_reset", 4'b0000, 0, 8'h00, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      req = 4'b1111;
      @(negedge clk);
      chk_all("post_reset_grant", 4'b0001, 1, 8'h00, 0, 0);
      @(negedge clk);
      chk_all("post_reset_commit", 4'b0000, 0, 8'hA5, 0, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin write arbiter for a single shared WIDTH-bit storage register built from D flip-flops with synchronous load. Up to NREQ requesters compete for write access. The block grants one requester at a time with a one-cycle grant pulse. It captures that requester's data into the shared register and reports which requester owns the current contents. The block sits between the requesting datapath stages and the storage flops, and is the only writer of those flops.

## Interface
Parameters:
- NREQ, 4, number of requesters (≥2)
- WIDTH, 8, width of the shared register and of each requester's data

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester write request, level; held until the matching gnt bit is seen
- wdata  in  NREQ*WIDTH  requester i's data in bits [i*WIDTH +: WIDTH]
- clr  in  1  synchronous clear of shared register contents
- gnt  out  NREQ  one-hot grant pulse, registered
- busy  out  1  high while in GRANT state
- q  out  WIDTH  shared register contents
- q_owner  out  $clog2(NREQ)  index of the requester whose data is in q
- q_valid  out  1  q holds written data (not reset/cleared)

## Operation
- The FSM has two states:
  - IDLE: if any req bit is high, pick the winner, load gnt with the winner one-hot, latch the winner index internally, and go to GRANT. Otherwise stay in IDLE with gnt = 0.
  - GRANT: gnt is high for this single cycle. At the closing edge:
    - q <= wdata slice of the winner
    - q_owner <= winner
    - q_valid <= 1
    - ptr <= winner
    - gnt <= 0
    - next state is IDLE
- Round-robin selection: scan from ptr+1 upward, wrapping modulo NREQ. The first requester found with req high wins. The requester just served therefore has the lowest priority in the next arbitration.
- The write is committed once in GRANT. If the winner drops req during the GRANT cycle, the write still happens with the wdata present on that cycle.
- clr is honoured in any state. At the edge it sets q <= 0 and q_valid <= 0; q_owner is unchanged.
  - If clr coincides with a GRANT commit, clr wins and no write occurs.
  - ptr still advances, and the FSM still returns to IDLE.
- busy = (state == GRANT), decoded combinationally from the state register.
- Reset values: state IDLE; ptr = NREQ-1, so requester 0 has first priority; gnt 0; q 0; q_owner 0; q_valid 0; busy 0.

## Timing
- Latency: req seen in IDLE on cycle n → gnt high during cycle n+1 → q, q_owner and q_valid updated from cycle n+2.
- Peak throughput is one write per 2 cycles. With continuous requests, gnt pulses on alternate cycles.
- A requester must keep req and wdata stable from assertion through its gnt cycle. It may deassert req on the cycle after gnt.
- gnt is never high in two consecutive cycles, and never has more than one bit set.
- A reset assertion mid-GRANT immediately clears gnt and busy and aborts the write. q returns to 0.
- A req change during GRANT does not affect the current grant. It is evaluated in the next IDLE cycle.

## Structure
- Shared package: the state enum typedef (IDLE, GRANT) and the default NREQ/WIDTH constants.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req, ptr.
  - Outputs: winner index and an any flag.
  - Implemented as a rotate, priority-encode and un-rotate.
- The top level holds the FSM, ptr, the gnt register and the storage flops.

## Test plan
- Reset, then req = 4'b0001 with wdata[0] = 8'hA5 → gnt = 0001 in cycle 2; q = A5, q_owner = 0, q_valid = 1 in cycle 3.
- req = 4'b1111 held continuously with distinct data per requester → gnt sequence 0001, 0010, 0100, 1000, 0001 on alternate cycles; q follows each requester's data with a 1-cycle lag.
- After requester 2 is served, req = 4'b0101 → requester 0 wins next (wrap), then requester 2.
- clr asserted during the GRANT cycle for requester 1 (wdata 8'h3C) → q = 0, q_valid = 0, no 3C written; the next grant goes to requester 2 or the wrap target.
- reset pulled low during GRANT → gnt, busy, q, q_valid all 0 asynchronously; after release, requester 0 has first priority again.
- Winner drops req during its GRANT cycle → write still committed with that cycle's wdata; no second grant to it unless req is re-raised.
